axi_slave_mem: RTL and testbench

- Synthesizable AXI3 slave that terminates a master's full AXI bus into an internal byte-enabled word memory.
- Parametrised successor to the fixed 32-bit/4-bit-ID slave channel bundle: generalises data/ID width and memory depth, and adds FIXED/INCR/WRAP burst address generation, independent write and read state machines, and protocol-error responses.
- Sits as the DUT-side responder behind the team's AXI UVC master agent, and as a memory model in subsystem benches.

---
 rtl/axi_slv_pkg.sv | 36 +++
 rtl/axi_slave_mem_if.sv | 72 +++++++
 rtl/axi_slv_addr_gen.sv | 31 +++
 rtl/axi_slave_mem.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI3 slave memory.
// Contents: burst/response encodings, write/read FSM state types and the
// byte-lane offset helper used to derive the word index from a byte address.
package axi_slv_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2,
      RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // Number of byte-offset address bits below the word index.
   function automatic int unsigned addr_lsb(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI3 bus bundle between a master and axi_slave_mem.
// Carries the AW, W, B, AR and R channels; lock/cache/prot are not carried.
// Modports: master (drives requests, write data, response readies),
//           slave  (drives address/data readies and the B/R channels).
interface axi_slave_mem_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
) ();
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [3:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;

   logic [ID_W-1:0]   wid;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;

   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;

   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_slv_addr_gen.sv
// Combinational next-beat address for an AXI burst.
// Ports: addr (current beat byte address), len (beats-1), size (log2 bytes
//        per beat), burst (FIXED/INCR/WRAP) -> next_addr.
module axi_slv_addr_gen
   import axi_slv_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        len,
   input  logic [2:0]        size,
   input  burst_e            burst,
   output logic [ADDR_W-1:0] next_addr
);
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] sum;

   always_comb begin
      incr      = ADDR_W'(1) << size;
      // Wrap block is (len+1)<<size bytes, aligned to its own size.
      wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      sum       = addr + incr;
      case (burst)
         FIXED:   next_addr = addr;
         INCR:    next_addr = sum;
         WRAP:    next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
         default: next_addr = addr;
      endcase
   end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave terminating a full AXI bus into a byte-enabled word memory.
// Ports: aclk (clock), arst (async active-high reset),
//        bus (axi_slave_mem_if.slave: AW/W/B/AR/R channels).
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs,
// FIXED/INCR/WRAP bursts, SLVERR on protocol errors.
// Build option AXI_SLV_OOR_SLVERR_EN: beats addressing beyond MEM_DEPTH get
// SLVERR instead of aliasing.
module axi_slave_mem
   import axi_slv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned MEM_DEPTH = 256
) (
   input logic           aclk,
   input logic           arst,
   axi_slave_mem_if.slave bus
);
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
   localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
   localparam logic [2:0]  MAX_SIZE = 3'(ADDR_LSB);

   function automatic logic req_err(input logic [3:0] len, input logic [2:0] size,
                                    input burst_e burst);
      logic bad_wrap;
      bad_wrap = (burst == WRAP) &&
                 !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
      return (burst == RSVD) || bad_wrap || (size > MAX_SIZE);
   endfunction

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // awready/arready stay low until the first edge after reset release.
   logic rdy_q;

   logic unused_wid;
   assign unused_wid = ^bus.wid;

   // ---------------- write path ----------------
   wr_state_e         wr_q, wr_d;
   logic [ID_W-1:0]   aw_id_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [3:0]        aw_len_q;
   logic [2:0]        aw_size_q;
   burst_e            aw_burst_q;
   logic [3:0]        wcnt_q;
   logic              werr_q;
   logic [ADDR_W-1:0] wr_next_addr;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_oor;
   logic              aw_hs, w_hs, w_final, w_done, w_beat_err;

   axi_slv_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr (
      .addr      (aw_addr_q),
      .len       (aw_len_q),
      .size      (aw_size_q),
      .burst     (aw_burst_q),
      .next_addr (wr_next_addr)
   );

   // ---------------- read path ----------------
   rd_state_e         rd_q, rd_d;
   logic [ID_W-1:0]   ar_id_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [3:0]        ar_len_q;
   logic [2:0]        ar_size_q;
   burst_e            ar_burst_q;
   logic [3:0]        rcnt_q;
   logic              rerr_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;
   logic [ADDR_W-1:0] rd_beat_addr, rd_next_addr;
   logic [3:0]        rd_len;
   logic [2:0]        rd_size;
   burst_e            rd_burst;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_oor, rd_req_err, rd_fetch_err;
   logic              ar_hs, r_hs, rd_idle, rd_fetch;

   // In R_IDLE the fetch uses the incoming request; afterwards the latched one.
   assign rd_idle      = (rd_q == R_IDLE);
   assign rd_beat_addr = rd_idle ? bus.araddr : rd_addr_q;
   assign rd_len       = rd_idle ? bus.arlen : ar_len_q;
   assign rd_size      = rd_idle ? bus.arsize : ar_size_q;
   assign rd_burst     = rd_idle ? burst_e'(bus.arburst) : ar_burst_q;

   axi_slv_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr (
      .addr      (rd_beat_addr),
      .len       (rd_len),
      .size      (rd_size),
      .burst     (rd_burst),
      .next_addr (rd_next_addr)
   );

   assign wr_idx = aw_addr_q[ADDR_LSB +: IDX_W];
   assign rd_idx = rd_beat_addr[ADDR_LSB +: IDX_W];

`ifdef AXI_SLV_OOR_SLVERR_EN
   assign wr_oor = |(aw_addr_q >> (ADDR_LSB + IDX_W));
   assign rd_oor = |(rd_beat_addr >> (ADDR_LSB + IDX_W));
`else
   assign wr_oor = 1'b0;
   assign rd_oor = 1'b0;
`endif

   // ---------------- write FSM ----------------
   assign aw_hs      = bus.awvalid & bus.awready;
   assign w_hs       = bus.wvalid & bus.wready;
   assign w_final    = (wcnt_q == aw_len_q);
   assign w_done     = w_final | bus.wlast;
   // wlast must coincide exactly with the final beat.
   assign w_beat_err = werr_q | (bus.wlast ^ w_final) | wr_oor;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) wr_q <= W_IDLE;
      else      wr_q <= wr_d;
   end

   always_comb begin
      wr_d = wr_q;
      unique case (wr_q)
         W_IDLE:  if (aw_hs) wr_d = W_DATA;
         W_DATA:  if (w_hs && w_done) wr_d = W_RESP;
         W_RESP:  if (bus.bready) wr_d = W_IDLE;
         default: wr_d = W_IDLE;
      endcase
   end

   always_comb begin
      bus.awready = rdy_q & (wr_q == W_IDLE);
      bus.wready  = (wr_q == W_DATA);
      bus.bvalid  = (wr_q == W_RESP);
      bus.bid     = bus.bvalid ? aw_id_q : '0;
      bus.bresp   = (bus.bvalid && werr_q) ? SLVERR : OKAY;
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         rdy_q      <= 1'b0;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= FIXED;
         wcnt_q     <= '0;
         werr_q     <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (aw_hs) begin
            aw_id_q    <= bus.awid;
            aw_addr_q  <= bus.awaddr;
            aw_len_q   <= bus.awlen;
            aw_size_q  <= bus.awsize;
            aw_burst_q <= burst_e'(bus.awburst);
            wcnt_q     <= '0;
            werr_q     <= req_err(bus.awlen, bus.awsize, burst_e'(bus.awburst));
         end else if (w_hs) begin
            aw_addr_q <= wr_next_addr;
            wcnt_q    <= wcnt_q + 4'd1;
            werr_q    <= w_beat_err;
         end
      end
   end

   // Memory array is not reset.
   always_ff @(posedge aclk) begin
      if (w_hs && !w_beat_err) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) mem[wr_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read FSM ----------------
   assign ar_hs        = bus.arvalid & bus.arready;
   assign r_hs         = bus.rvalid & bus.rready;
   assign rd_req_err   = rd_idle ? req_err(bus.arlen, bus.arsize, burst_e'(bus.arburst))
                                 : rerr_q;
   assign rd_fetch_err = rd_req_err | rd_oor;
   // Next beat loads on the same edge as the current handshake: no bubble.
   assign rd_fetch     = ar_hs | (r_hs & ~rlast_q);

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) rd_q <= R_IDLE;
      else      rd_q <= rd_d;
   end

   always_comb begin
      rd_d = rd_q;
      unique case (rd_q)
         R_IDLE:  if (ar_hs) rd_d = R_DATA;
         R_DATA:  if (r_hs && rlast_q) rd_d = R_IDLE;
         default: rd_d = R_IDLE;
      endcase
   end

   always_comb begin
      bus.arready = rdy_q & rd_idle;
      bus.rvalid  = (rd_q == R_DATA);
      bus.rid     = bus.rvalid ? ar_id_q : '0;
      bus.rdata   = bus.rvalid ? rdata_q : '0;
      bus.rresp   = bus.rvalid ? rresp_q : '0;
      bus.rlast   = bus.rvalid & rlast_q;
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         ar_id_q    <= '0;
         rd_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= FIXED;
         rcnt_q     <= '0;
         rerr_q     <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rlast_q    <= 1'b0;
      end else begin
         if (ar_hs) begin
            ar_id_q    <= bus.arid;
            ar_len_q   <= bus.arlen;
            ar_size_q  <= bus.arsize;
            ar_burst_q <= burst_e'(bus.arburst);
            rerr_q     <= rd_req_err;
         end
         if (rd_fetch) begin
            rdata_q   <= rd_fetch_err ? '0 : mem[rd_idx];
            rresp_q   <= rd_fetch_err ? SLVERR : OKAY;
            rlast_q   <= rd_idle ? (bus.arlen == 4'd0) : ((rcnt_q + 4'd1) == ar_len_q);
            rcnt_q    <= rd_idle ? 4'd0 : (rcnt_q + 4'd1);
            rd_addr_q <= rd_next_addr;
         end
      end
   end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (default build).
module tb_axi_slave_mem;
   logic aclk;
   logic arst;
   int   n_checks = 0;
   int   n_errors = 0;

   axi_slave_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

   axi_slave_mem #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .ID_W      (4),
      .MEM_DEPTH (256)
   ) dut (
      .aclk (aclk),
      .arst (arst),
      .bus  (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      bus.awid = id; bus.awaddr = addr; bus.awlen = len;
      bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
      while (!bus.awready && n < 50) begin tick(); n++; end
      if (!bus.awready) check("aw_timeout", 64'(bus.awready), 1);
      tick();
      bus.awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
      while (!bus.wready && n < 50) begin tick(); n++; end
      if (!bus.wready) check("w_timeout", 64'(bus.wready), 1);
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
   endtask

   task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
      int n = 0;
      bus.bready = 1'b1;
      while (!bus.bvalid && n < 50) begin tick(); n++; end
      check({tag, "_bvalid"}, 64'(bus.bvalid), 1);
      check({tag, "_bresp"}, 64'(bus.bresp), 64'(resp));
      check({tag, "_bid"}, 64'(bus.bid), 64'(id));
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      bus.arid = id; bus.araddr = addr; bus.arlen = len;
      bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
      while (!bus.arready && n < 50) begin tick(); n++; end
      if (!bus.arready) check("ar_timeout", 64'(bus.arready), 1);
      tick();
      bus.arvalid = 1'b0;
   endtask

   task automatic r_recv(input string tag, input logic [31:0] data, input logic last,
                         input logic [1:0] resp, input logic [3:0] id);
      int n = 0;
      bus.rready = 1'b1;
      while (!bus.rvalid && n < 50) begin tick(); n++; end
      check({tag, "_rvalid"}, 64'(bus.rvalid), 1);
      check({tag, "_rdata"}, 64'(bus.rdata), 64'(data));
      check({tag, "_rlast"}, 64'(bus.rlast), 64'(last));
      check({tag, "_rresp"}, 64'(bus.rresp), 64'(resp));
      check({tag, "_rid"}, 64'(bus.rid), 64'(id));
      tick();
      bus.rready = 1'b0;
   endtask

   initial begin
      arst = 1'b1;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
      bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      // Reset state.
      tick(); tick();
      check("rst_awready", 64'(bus.awready), 0);
      check("rst_arready", 64'(bus.arready), 0);
      check("rst_wready", 64'(bus.wready), 0);
      check("rst_bvalid", 64'(bus.bvalid), 0);
      check("rst_rvalid", 64'(bus.rvalid), 0);
      arst = 1'b0;
      #1;
      check("rel_awready_pre", 64'(bus.awready), 0);
      tick();
      check("rel_awready", 64'(bus.awready), 1);
      check("rel_arready", 64'(bus.arready), 1);

      // INCR write 0x10..0x1C, then read back.
      aw_send(4'd5, 32'h10, 4'd3, 3'd2, 2'd1);
      for (int i = 0; i < 4; i++) w_send(32'hA0 + 32'(i), 4'hF, i == 3);
      b_recv("incr_wr", 2'b00, 4'd5);
      ar_send(4'd6, 32'h10, 4'd3, 3'd2, 2'd1);
      for (int i = 0; i < 4; i++) r_recv("incr_rd", 32'hA0 + 32'(i), i == 3, 2'b00, 4'd6);

      // WRAP read over 0x30..0x3C starting at 0x38.
      aw_send(4'd1, 32'h30, 4'd3, 3'd2, 2'd1);
      for (int i = 0; i < 4; i++) w_send(32'hB0 + 32'(i), 4'hF, i == 3);
      b_recv("wrap_fill", 2'b00, 4'd1);
      ar_send(4'd2, 32'h38, 4'd3, 3'd2, 2'd2);
      r_recv("wrap_b0", 32'hB2, 1'b0, 2'b00, 4'd2);
      r_recv("wrap_b1", 32'hB3, 1'b0, 2'b00, 4'd2);
      r_recv("wrap_b2", 32'hB0, 1'b0, 2'b00, 4'd2);
      r_recv("wrap_b3", 32'hB1, 1'b1, 2'b00, 4'd2);

      // Read backpressure: rready 1-0-0-1.
      ar_send(4'd9, 32'h10, 4'd1, 3'd2, 2'd1);
      r_recv("bp_b0", 32'hA0, 1'b0, 2'b00, 4'd9);
      for (int i = 0; i < 2; i++) begin
         check("bp_stall_rvalid", 64'(bus.rvalid), 1);
         check("bp_stall_rdata", 64'(bus.rdata), 64'h A1);
         check("bp_stall_rid", 64'(bus.rid), 64'd9);
         tick();
      end
      r_recv("bp_b1", 32'hA1, 1'b1, 2'b00, 4'd9);

      // Write response backpressure.
      aw_send(4'd3, 32'h40, 4'd0, 3'd2, 2'd1);
      w_send(32'hC0, 4'hF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bbp_bvalid", 64'(bus.bvalid), 1);
         check("bbp_awready", 64'(bus.awready), 0);
         tick();
      end
      b_recv("bbp", 2'b00, 4'd3);
      check("bbp_awready_after", 64'(bus.awready), 1);

      // Reserved burst: SLVERR, memory unchanged.
      aw_send(4'd4, 32'h10, 4'd0, 3'd2, 2'd3);
      w_send(32'hDEAD, 4'hF, 1'b1);
      b_recv("rsvd_wr", 2'b10, 4'd4);
      ar_send(4'd0, 32'h10, 4'd0, 3'd2, 2'd1);
      r_recv("rsvd_chk", 32'hA0, 1'b1, 2'b00, 4'd0);

      // Early wlast on beat 1 of a 4-beat burst.
      aw_send(4'd7, 32'h50, 4'd3, 3'd2, 2'd1);
      w_send(32'hE0, 4'hF, 1'b0);
      w_send(32'hE1, 4'hF, 1'b1);
      b_recv("early_wlast", 2'b10, 4'd7);

      // WRAP with illegal length: SLVERR, zero data, 3 beats.
      ar_send(4'd8, 32'h10, 4'd2, 3'd2, 2'd2);
      for (int i = 0; i < 3; i++) r_recv("wrap_len_err", 32'h0, i == 2, 2'b10, 4'd8);

      // Oversized beat: SLVERR.
      ar_send(4'd8, 32'h10, 4'd0, 3'd3, 2'd1);
      r_recv("size_err", 32'h0, 1'b1, 2'b10, 4'd8);

      // Partial strobes.
      aw_send(4'd2, 32'h60, 4'd0, 3'd2, 2'd1);
      w_send(32'hFFFF_FFFF, 4'hF, 1'b1);
      b_recv("strb_fill", 2'b00, 4'd2);
      aw_send(4'd2, 32'h60, 4'd0, 3'd2, 2'd1);
      w_send(32'h1234_5678, 4'h5, 1'b1);
      b_recv("strb_wr", 2'b00, 4'd2);
      ar_send(4'd2, 32'h60, 4'd0, 3'd2, 2'd1);
      r_recv("strb_rd", 32'hFF34_FF78, 1'b1, 2'b00, 4'd2);

      // Reset mid-write at beat 2.
      aw_send(4'd1, 32'h70, 4'd3, 3'd2, 2'd1);
      for (int i = 0; i < 4; i++) w_send(32'h1111_1111, 4'hF, i == 3);
      b_recv("mid_fill", 2'b00, 4'd1);
      ar_send(4'd3, 32'h10, 4'd3, 3'd2, 2'd1);
      aw_send(4'd5, 32'h70, 4'd3, 3'd2, 2'd1);
      w_send(32'hD0, 4'hF, 1'b0);
      w_send(32'hD1, 4'hF, 1'b0);
      bus.wdata = 32'hD2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      #3;
      arst = 1'b1;
      #1;
      check("mid_rst_awready", 64'(bus.awready), 0);
      check("mid_rst_wready", 64'(bus.wready), 0);
      check("mid_rst_bvalid", 64'(bus.bvalid), 0);
      check("mid_rst_arready", 64'(bus.arready), 0);
      check("mid_rst_rvalid", 64'(bus.rvalid), 0);
      check("mid_rst_rdata", 64'(bus.rdata), 0);
      bus.wvalid = 1'b0;
      tick();
      arst = 1'b0;
      tick();
      ar_send(4'd6, 32'h70, 4'd2, 3'd2, 2'd1);
      r_recv("mid_rd_b0", 32'hD0, 1'b0, 2'b00, 4'd6);
      r_recv("mid_rd_b1", 32'hD1, 1'b0, 2'b00, 4'd6);
      r_recv("mid_rd_b2", 32'h1111_1111, 1'b1, 2'b00, 4'd6);
      aw_send(4'd9, 32'h80, 4'd0, 3'd2, 2'd0);
      w_send(32'h5A5A_0F0F, 4'hF, 1'b1);
      b_recv("post_rst_wr", 2'b00, 4'd9);
      ar_send(4'd9, 32'h80, 4'd0, 3'd2, 2'd0);
      r_recv("post_rst_rd", 32'h5A5A_0F0F, 1'b1, 2'b00, 4'd9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
